// File: rtl/wide_word_serializer.sv
// Serializes one wide word into a stream of WORD_WIDTH slices, LSB slice first,
// with m_last on the final zero-padded slice and no bubble between packets.
module wide_word_serializer #(
  parameter int IN_WIDTH = 131,
  parameter int WORD_WIDTH = 32,
  localparam int NUM_WORDS = (IN_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      m_index
);

  localparam int HOLD_W = NUM_WORDS * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] hold;
  logic accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        hold <= HOLD_W'(s_data);
      end
    end
  end

  // The last-slice handshake frees the holder, so a new word can load on that same edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    m_valid    = (state == SEND);
    m_last     = m_valid && (cnt == LAST_IDX);
    m_index    = cnt;
    m_data     = m_valid ? hold[cnt] : '0;
    s_ready    = (state == IDLE) || (m_valid && m_ready && m_last);
    accept     = s_valid && s_ready;
    if (accept) begin
      state_next = SEND;
      cnt_next   = '0;
    end else if (m_valid && m_ready) begin
      if (m_last) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wide_word_serializer.sv
// Directed bench for wide_word_serializer: default 131-bit instance plus
// 32- and 33-bit instances for the single/double-beat corner cases.
module tb_wide_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [130:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         m_last;
  logic [2:0]   m_index;

  logic        s_valid32 = 1'b0;
  logic        s_ready32;
  logic [31:0] s_data32 = '0;
  logic        m_valid32;
  logic        m_ready32 = 1'b0;
  logic [31:0] m_data32;
  logic        m_last32;
  logic [0:0]  m_index32;

  logic        s_valid33 = 1'b0;
  logic        s_ready33;
  logic [32:0] s_data33 = '0;
  logic        m_valid33;
  logic        m_ready33 = 1'b0;
  logic [31:0] m_data33;
  logic        m_last33;
  logic [0:0]  m_index33;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] wordsA [5];
  logic [31:0] wordsOnes [5];

  wide_word_serializer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_index(m_index)
  );

  wide_word_serializer #(.IN_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid32), .s_ready(s_ready32), .s_data(s_data32),
    .m_valid(m_valid32), .m_ready(m_ready32), .m_data(m_data32),
    .m_last(m_last32), .m_index(m_index32)
  );

  wide_word_serializer #(.IN_WIDTH(33)) dut33 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid33), .s_ready(s_ready33), .s_data(s_data33),
    .m_valid(m_valid33), .m_ready(m_ready33), .m_data(m_data33),
    .m_last(m_last33), .m_index(m_index33)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checkCount++;
    assert (obs === want) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One packet with m_ready held high; outputs are sampled on the falling edge.
  task automatic applyStimulus(input string name, input logic [130:0] data, input logic [31:0] want [5]);
    @(negedge clk);
    checkOutput({name, "_idle_s_ready"}, 32'(s_ready), 32'd1);
    s_data  = data;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_b%0d_valid", name, i), 32'(m_valid), 32'd1);
      checkOutput($sformatf("%s_b%0d_data", name, i), m_data, want[i]);
      checkOutput($sformatf("%s_b%0d_index", name, i), 32'(m_index), 32'(i));
      checkOutput($sformatf("%s_b%0d_last", name, i), 32'(m_last), (i == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s_b%0d_s_ready", name, i), 32'(s_ready), (i == 4) ? 32'd1 : 32'd0);
      s_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput({name, "_after_valid"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [130:0] dataA;
    logic [130:0] dataB;
    logic [130:0] rnd;
    logic [159:0] raw;
    logic [159:0] ext;
    logic [31:0]  b2b [10];
    logic [31:0]  w [5];
    int idx;
    int cyc;

    dataA = 131'h5_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    wordsA[0] = 32'hAAAAAAAA; wordsA[1] = 32'hBBBBBBBB; wordsA[2] = 32'hCCCCCCCC;
    wordsA[3] = 32'hDDDDDDDD; wordsA[4] = 32'h00000005;
    for (int i = 0; i < 4; i++) wordsOnes[i] = 32'hFFFFFFFF;
    wordsOnes[4] = 32'h00000007;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_m_index", 32'(m_index), 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_s_ready", 32'(s_ready), 32'd1);

    $display("[TB] single packet and padding");
    applyStimulus("single", dataA, wordsA);
    applyStimulus("ones", {131{1'b1}}, wordsOnes);

    $display("[TB] back-to-back packets");
    dataB = 131'h3_44444444_33333333_22222222_11111111;
    for (int i = 0; i < 5; i++) b2b[i] = wordsA[i];
    b2b[5] = 32'h11111111; b2b[6] = 32'h22222222; b2b[7] = 32'h33333333;
    b2b[8] = 32'h44444444; b2b[9] = 32'h00000003;
    @(negedge clk);
    s_data  = dataA;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_%0d_valid", i), 32'(m_valid), 32'd1);
      checkOutput($sformatf("b2b_%0d_data", i), m_data, b2b[i]);
      checkOutput($sformatf("b2b_%0d_index", i), 32'(m_index), 32'(i % 5));
      checkOutput($sformatf("b2b_%0d_last", i), 32'(m_last), (i % 5 == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b_%0d_s_ready", i), 32'(s_ready), (i % 5 == 4) ? 32'd1 : 32'd0);
      if (i == 0) s_data = dataB;
      if (i == 5) s_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("b2b_after_valid", 32'(m_valid), 32'd0);

    $display("[TB] backpressure");
    for (int p = 0; p < 20; p++) begin
      raw = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rnd = raw[130:0];
      ext = {29'b0, rnd};
      for (int k = 0; k < 5; k++) w[k] = ext[k*32 +: 32];
      @(negedge clk);
      s_data  = rnd;
      s_valid = 1'b1;
      m_ready = 1'($urandom_range(0, 1));
      idx = 0;
      cyc = 0;
      while (idx < 5 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        s_valid = 1'b0;
        checkOutput($sformatf("bp%0d_valid", p), 32'(m_valid), 32'd1);
        checkOutput($sformatf("bp%0d_data%0d", p, idx), m_data, w[idx]);
        checkOutput($sformatf("bp%0d_index", p), 32'(m_index), 32'(idx));
        checkOutput($sformatf("bp%0d_last", p), 32'(m_last), (idx == 4) ? 32'd1 : 32'd0);
        m_ready = 1'($urandom_range(0, 1));
        if (m_ready) idx++;
      end
      checkOutput($sformatf("bp%0d_done", p), 32'(idx), 32'd5);
      @(negedge clk);
      checkOutput($sformatf("bp%0d_after_valid", p), 32'(m_valid), 32'd0);
    end

    $display("[TB] reset mid-packet");
    @(negedge clk);
    s_data  = dataA;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      checkOutput($sformatf("mid_b%0d_data", i), m_data, wordsA[i]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_m_index", 32'(m_index), 32'd0);
    checkOutput("mid_rst_m_data", m_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_release_m_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_release_s_ready", 32'(s_ready), 32'd1);
    applyStimulus("after_rst", dataA, wordsA);

    $display("[TB] narrow widths");
    @(negedge clk);
    s_data32  = 32'h12345678;
    s_valid32 = 1'b1;
    m_ready32 = 1'b1;
    s_data33  = 33'h1_87654321;
    s_valid33 = 1'b1;
    m_ready33 = 1'b1;
    @(negedge clk);
    s_valid32 = 1'b0;
    s_valid33 = 1'b0;
    checkOutput("w32_valid", 32'(m_valid32), 32'd1);
    checkOutput("w32_data", m_data32, 32'h12345678);
    checkOutput("w32_last", 32'(m_last32), 32'd1);
    checkOutput("w32_index", 32'(m_index32), 32'd0);
    checkOutput("w32_s_ready", 32'(s_ready32), 32'd1);
    checkOutput("w33_b0_valid", 32'(m_valid33), 32'd1);
    checkOutput("w33_b0_data", m_data33, 32'h87654321);
    checkOutput("w33_b0_last", 32'(m_last33), 32'd0);
    checkOutput("w33_b0_s_ready", 32'(s_ready33), 32'd0);
    @(negedge clk);
    checkOutput("w32_after_valid", 32'(m_valid32), 32'd0);
    checkOutput("w33_b1_valid", 32'(m_valid33), 32'd1);
    checkOutput("w33_b1_data", m_data33, 32'h00000001);
    checkOutput("w33_b1_last", 32'(m_last33), 32'd1);
    checkOutput("w33_b1_index", 32'(m_index33), 32'd1);
    @(negedge clk);
    checkOutput("w33_after_valid", 32'(m_valid33), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wide_word_serializer.md
# wide_word_serializer

Sequencer that accepts one wide word (default 131 bits) over a valid/ready handshake and emits it as a stream of 32-bit words, LSB-first, one word per accepted output beat, with a last flag on the final word. It is the controlling counterpart of the combinational word splitter. It holds the wide word, selects one 32-bit slice per beat and zero-pads the final partial slice. It sits between the wide result/config producer and the 32-bit AXI-Stream path toward the DMA.

## Interface

Parameters:
- `IN_WIDTH`, 131, width of the wide input word; must be ≥ 1.
- `WORD_WIDTH`, 32, width of each output word.
- `NUM_WORDS`, derived as ceil(`IN_WIDTH`/`WORD_WIDTH`), default 5; not overridable.
- `CNT_W`, derived as max(1, ceil(log2(`NUM_WORDS`))), default 3.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `s_valid`  in  1  wide word available.
- `s_ready`  out  1  block can accept a wide word this cycle.
- `s_data`  in  `IN_WIDTH`  wide word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the output word.
- `m_data`  out  `WORD_WIDTH`  current slice.
- `m_last`  out  1  high on slice `NUM_WORDS`-1.
- `m_index`  out  `CNT_W`  index of the current slice, 0..`NUM_WORDS`-1.

## Operation

- States:
  - IDLE: no word held.
  - SEND: word held; `m_valid`=1.
- Input handshake:
  - Accept when `s_valid & s_ready`.
  - `s_ready = (state==IDLE) | (m_valid & m_ready & m_last)`, which gives back-to-back packets with no bubble.
  - `s_ready` depends combinationally on `m_ready`; there is no path from `s_valid` to `s_ready`.
- On accept:
  - Hold register ← `s_data`, zero-extended to `NUM_WORDS`×`WORD_WIDTH` bits.
  - Counter ← 0.
  - State → SEND.
- In SEND:
  - `m_data` = hold[(cnt+1)·W−1 : cnt·W].
  - `m_index` = cnt.
  - `m_last` = (cnt==`NUM_WORDS`−1).
- Output handshake `m_valid & m_ready`, when not last: cnt ← cnt+1. Data, index and last are otherwise stable while `m_valid & ~m_ready` (AXI-Stream stability rule).
- Output handshake on the last slice:
  - If `s_valid`=1: accept the new word in the same cycle; stay in SEND with cnt ← 0.
  - If `s_valid`=0: state → IDLE, cnt ← 0.
- Final slice padding: bits above `IN_WIDTH` read as 0. Default: `m_data` on slice 4 = {29'b0, s_data[130:128]}.
- `NUM_WORDS`=1 (`IN_WIDTH` ≤ 32): every beat is last, with padding to `WORD_WIDTH`.
- The hold register is written only on input accept; `s_data` changes at other times are ignored.

## Timing

- Reset (`rst`=1 at an edge) sets:
  - state=IDLE, cnt=0, hold=0.
  - `m_valid`=0, `m_last`=0, `m_index`=0, `m_data`=0.
  - `s_ready`=1 from the first cycle after reset deasserts.
- Reset mid-packet: the partially sent word is discarded. The cycle after the reset edge has `m_valid`=0, and no further slices of that word appear.
- Latency: accept at edge N gives slice 0 valid after edge N (`m_valid` registered, no combinational s→m path).
- Throughput:
  - With `m_ready` held high: one slice per cycle.
  - A packet occupies exactly `NUM_WORDS` cycles.
  - Continuous input gives 100% output utilisation.
- Simultaneous last-slice handshake and new input: both fire at the same edge. The next cycle shows slice 0 of the new word.
- `m_ready` toggling: each slice is held until accepted. Slices are never skipped or duplicated.
- `s_ready`=0 for the whole of SEND except on a last-slice handshake cycle.

## Test plan

- Single packet, `m_ready`=1: `s_data` = 131'h5_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA gives 5 beats on consecutive cycles:
  - AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD, 00000005.
  - `m_index` 0..4; `m_last` only on beat 4.
  - `s_ready`=0 during beats 0–3.
- Back-to-back: two words offered with `s_valid` held and `m_ready`=1 give 10 beats over 10 consecutive cycles with no `m_valid` gap. The second word is accepted on the edge of the first word's last beat.
- Backpressure: `m_ready` pseudo-random (50%) over 20 packets gives every slice exactly once, in order, with `m_data`/`m_last`/`m_index` stable while stalled. The scoreboard output matches the input split and pad.
- Padding check: input with all 131 bits 1 gives the last beat = 32'h0000_0007; the other beats are FFFFFFFF.
- Reset mid-packet: assert `rst` after beat 2 is accepted. Next cycle `m_valid`=0 and `s_ready`=1 after release. A following packet streams from index 0 correctly.
- Parameter sweep: `IN_WIDTH`=32 gives 1 beat with `m_last`=1. `IN_WIDTH`=33 gives 2 beats, the second = {31'b0, bit32}.
